wb_stage: RTL and testbench

- Memory/writeback stage of the 3-stage RV32I pipeline; sits directly upstream of the register file and drives its write port (rf_en, rd, wdata).
- Latches execute-stage results into the MEM/WB pipeline register and aligns and extends load data from data memory.
- Selects the writeback source and maintains the 64-bit retired-instruction counter (instret) consumed by the CSR unit.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_stage_load_align.sv | 31 +++
 rtl/wb_stage.sv | 93 +++++++++
 tb/tb_wb_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the memory/writeback stage.
package wb_pkg;

  localparam int unsigned XLEN_DEF = 32;

  // Writeback source select
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_CSR  = 2'b11
  } wb_sel_e;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/wb_stage_load_align.sv
// Byte/half/word extraction and extension of load data.
module load_align
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      mem_op,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte/half, then extend per funct3; half select ignores off[0]
  always_comb begin
    byte_sel = 8'(rdata >> {off, 3'b000});
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    data     = rdata;
    case (mem_op)
      LB:      data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LBU:     data = {{(XLEN-8){1'b0}}, byte_sel};
      LH:      data = {{(XLEN-16){half_sel[15]}}, half_sel};
      LHU:     data = {{(XLEN-16){1'b0}}, half_sel};
      LW:      data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, writeback mux, register-file write port and instret.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic             ex_rf_en,
  input  logic [4:0]       ex_rd,
  input  logic [1:0]       ex_wb_sel,
  input  logic [2:0]       ex_mem_op,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_csr_rdata,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             rf_en,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  wdata,
  output logic [CNT_W-1:0] instret
);

  logic            valid_q;
  logic            rf_en_q;
  logic [4:0]      rd_q;
  wb_sel_e         wb_sel_q;
  logic [2:0]      mem_op_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] csr_q;
  logic [XLEN-1:0] load_data;

  // MEM/WB register: flush beats stall, stall holds, otherwise capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      rf_en_q  <= 1'b0;
      rd_q     <= '0;
      wb_sel_q <= WB_ALU;
      mem_op_q <= '0;
      alu_q    <= '0;
      pc_q     <= '0;
      csr_q    <= '0;
    end else if (flush) begin
      valid_q  <= 1'b0;
      rf_en_q  <= 1'b0;
    end else if (!stall) begin
      valid_q  <= ex_valid;
      rf_en_q  <= ex_rf_en;
      rd_q     <= ex_rd;
      wb_sel_q <= wb_sel_e'(ex_wb_sel);
      mem_op_q <= ex_mem_op;
      alu_q    <= ex_alu_result;
      pc_q     <= ex_pc;
      csr_q    <= ex_csr_rdata;
    end
  end

  // Retire counter: one count per instruction, on the cycle it leaves WB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= '0;
    end else if (valid_q && !stall) begin
      instret <= instret + CNT_W'(1);
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata  (dmem_rdata),
    .off    (alu_q[1:0]),
    .mem_op (mem_op_q),
    .data   (load_data)
  );

  // Write port: suppressed for bubbles, stalls and x0
  always_comb begin
    rf_en = valid_q & rf_en_q & ~stall & (rd_q != '0);
    rd    = rd_q;
    wdata = alu_q;
    case (wb_sel_q)
      WB_ALU:  wdata = alu_q;
      WB_LOAD: wdata = load_data;
      WB_PC4:  wdata = pc_q + XLEN'(4);
      WB_CSR:  wdata = csr_q;
      default: wdata = alu_q;
    endcase
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: driver queues expected writes, monitor checks them.
module tb_wb_stage;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        ex_valid, ex_rf_en;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wb_sel;
  logic [2:0]  ex_mem_op;
  logic [31:0] ex_alu_result, ex_pc, ex_csr_rdata, dmem_rdata;
  logic        rf_en;
  logic [4:0]  rd;
  logic [31:0] wdata;
  logic [63:0] instret;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          id;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          wr_id  = 0;
  logic [63:0] exp_cnt;

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_rf_en(ex_rf_en), .ex_rd(ex_rd),
    .ex_wb_sel(ex_wb_sel), .ex_mem_op(ex_mem_op),
    .ex_alu_result(ex_alu_result), .ex_pc(ex_pc),
    .ex_csr_rdata(ex_csr_rdata), .dmem_rdata(dmem_rdata),
    .rf_en(rf_en), .rd(rd), .wdata(wdata), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.rd = r; e.data = d; e.id = wr_id;
    wr_id++;
    exp_q.push_back(e);
  endtask

  // Present one instruction; returns just after the capturing edge
  task automatic drive(input logic v, input logic en, input logic [4:0] r,
                       input logic [1:0] sel, input logic [2:0] op,
                       input logic [31:0] alu, input logic [31:0] pc,
                       input logic [31:0] csr);
    ex_valid = v; ex_rf_en = en; ex_rd = r; ex_wb_sel = sel;
    ex_mem_op = op; ex_alu_result = alu; ex_pc = pc; ex_csr_rdata = csr;
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    ex_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: every asserted write must match the oldest expected write
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (rf_en === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write actual rd=%0d wdata=%h required no write", rd, wdata);
        end else begin
          e = exp_q.pop_front();
          if (rd !== e.rd || wdata !== e.data) begin
            errors++;
            $display("FAIL write_%0d actual rd=%0d wdata=%h required rd=%0d wdata=%h",
                     e.id, rd, wdata, e.rd, e.data);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    ex_valid = 1'b0; ex_rf_en = 1'b0; ex_rd = '0; ex_wb_sel = '0; ex_mem_op = '0;
    ex_alu_result = '0; ex_pc = '0; ex_csr_rdata = '0;
    dmem_rdata = 32'h80F0_7F81;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_en", 64'(rf_en), 64'd0);
    check("reset_instret", instret, 64'd0);
    rst = 1'b0;
    idle(1);
    check("post_reset_rf_en", 64'(rf_en), 64'd0);

    // One retire, then reset while an instruction sits in WB
    expect_wr(5'd3, 32'h0000_0055);
    drive(1, 1, 5'd3, WB_ALU, LW, 32'h55, 32'h0, 32'h0);
    idle(1);
    check("instret_one", instret, 64'd1);
    drive(1, 1, 5'd7, WB_ALU, LW, 32'hAAAA, 32'h0, 32'h0);
    #1 rst = 1'b1;
    #1;
    check("midreset_rf_en", 64'(rf_en), 64'd0);
    check("midreset_instret", instret, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_wr(5'd5, 32'h0000_1234);
    drive(1, 1, 5'd5, WB_ALU, LW, 32'h1234, 32'h0, 32'h0);
    check("first_write_rf_en", 64'(rf_en), 64'd1);
    exp_cnt = 64'd1;

    // Load alignment against dmem_rdata = 0x80F0_7F81
    expect_wr(5'd1, 32'hFFFF_FF81);
    drive(1, 1, 5'd1, WB_LOAD, LB,  32'h1000, 32'h0, 32'h0);
    expect_wr(5'd2, 32'h0000_007F);
    drive(1, 1, 5'd2, WB_LOAD, LBU, 32'h1001, 32'h0, 32'h0);
    expect_wr(5'd3, 32'hFFFF_80F0);
    drive(1, 1, 5'd3, WB_LOAD, LH,  32'h1002, 32'h0, 32'h0);
    expect_wr(5'd4, 32'h0000_80F0);
    drive(1, 1, 5'd4, WB_LOAD, LHU, 32'h1002, 32'h0, 32'h0);
    expect_wr(5'd6, 32'h80F0_7F81);
    drive(1, 1, 5'd6, WB_LOAD, LW,  32'h1000, 32'h0, 32'h0);
    exp_cnt += 5;

    // Writeback sources
    expect_wr(5'd8, 32'h0000_0104);
    drive(1, 1, 5'd8, WB_PC4, LW, 32'h0, 32'h0000_0100, 32'h0);
    expect_wr(5'd9, 32'h0000_0000);
    drive(1, 1, 5'd9, WB_PC4, LW, 32'h0, 32'hFFFF_FFFC, 32'h0);
    expect_wr(5'd10, 32'hDEAD_BEEF);
    drive(1, 1, 5'd10, WB_CSR, LW, 32'h0, 32'h0, 32'hDEAD_BEEF);
    exp_cnt += 3;
    idle(1);
    check("instret_after_sources", instret, exp_cnt);

    // rd = x0: no write, still counted
    drive(1, 1, 5'd0, WB_ALU, LW, 32'hFFFF, 32'h0, 32'h0);
    check("x0_rf_en", 64'(rf_en), 64'd0);
    idle(1);
    exp_cnt += 1;
    check("x0_instret", instret, exp_cnt);

    // Three-cycle stall on a valid instruction
    expect_wr(5'd11, 32'h0000_0ABC);
    drive(1, 1, 5'd11, WB_ALU, LW, 32'hABC, 32'h0, 32'h0);
    stall = 1'b1;
    #1;
    check("stall_rf_en", 64'(rf_en), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("stall_instret_hold", instret, exp_cnt);
    stall = 1'b0;
    #1;
    check("stall_release_rf_en", 64'(rf_en), 64'd1);
    idle(1);
    exp_cnt += 1;
    check("stall_instret_once", instret, exp_cnt);
    idle(1);
    check("stall_instret_stable", instret, exp_cnt);

    // Stall and flush together: squashed, no write, no count
    drive(1, 1, 5'd12, WB_ALU, LW, 32'h777, 32'h0, 32'h0);
    stall = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    stall = 1'b0; flush = 1'b0;
    #1;
    check("flush_rf_en", 64'(rf_en), 64'd0);
    idle(2);
    check("flush_instret", instret, exp_cnt);

    // Ten back-to-back retires from a clean count
    rst = 1'b1;
    #2 rst = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      expect_wr(5'(i + 1), 32'(i * 3 + 1));
      drive(1, 1, 5'(i + 1), WB_ALU, LW, 32'(i * 3 + 1), 32'h0, 32'h0);
    end
    idle(1);
    check("instret_ten", instret, 64'd10);

    // Counter wrap from all-ones
    force dut.instret = '1;
    #1 release dut.instret;
    #1;
    check("instret_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1, 0, 5'd13, WB_ALU, LW, 32'h0, 32'h0, 32'h0);
    idle(1);
    check("instret_wrap", instret, 64'd0);

    idle(3);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
